axis_out_master: RTL

AXI4-Stream master output stage fed by the data path's result bus (`M_AXIS_o_valid/data/last` from the psum or pooling packers). The producer has no backpressure input, so this block buffers results in a show-ahead FIFO, presents them on the `M_AXIS_*` master port under TREADY flow control, and raises `almost_full` so the controller can stall MAC issue. It also tracks each layer's output packet (beat count, completion pulse) and flags data loss.

---
 rtl/axis_out_pkg.sv | 23 ++
 rtl/axis_out_fifo.sv | 53 +++++
 rtl/axis_out_master.sv | 111 +++++++++++
 3 files changed

// File: rtl/axis_out_pkg.sv
// Shared types and helpers for the AXI4-Stream output stage.
package axis_out_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  // ceil(log2(value)), minimum 0
  function automatic int clogb2(input int value);
    int v;
    int r;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_out_fifo.sv
// Show-ahead FIFO holding {last, data}; push/pop arrive already qualified.
module axis_out_fifo
  import axis_out_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int AW    = clogb2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          wr_last,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          rd_last,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  always_ff @(posedge clk)
    if (push) mem[wptr] <= {wr_last, wr_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign {rd_last, rd_data} = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/axis_out_master.sv
// AXI4-Stream master output stage: buffers result words, tracks packet
// progress and reports stall/loss to the controller.
module axis_out_master
  import axis_out_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 16,
  parameter int ALMOST_FULL_MARGIN   = 4,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              in_valid,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   in_data,
  input  logic                              in_last,
  output logic                              almost_full,
  output logic                              overflow,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic [CNT_WIDTH-1:0]              beat_count,
  output logic                              layer_done,
  output logic                              busy
);

  localparam int AW = clogb2(FIFO_DEPTH);

  logic                            push, pop, last_hs, last_hs_q;
  logic                            full, empty, head_last;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] head_data;
  logic [AW:0]                     count, free;
  state_e                          state, state_nxt;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop     = ~empty & M_AXIS_TREADY & ~clear;
  assign push    = in_valid & ~clear & (~full | pop);
  assign last_hs = pop & head_last;

  axis_out_fifo #(
    .W     (C_M_AXIS_TDATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .push    (push),
    .wr_data (in_data),
    .wr_last (in_last),
    .pop     (pop),
    .rd_data (head_data),
    .rd_last (head_last),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Head is masked while empty so the port idles at zero.
  assign M_AXIS_TVALID = ~empty;
  assign M_AXIS_TDATA  = empty ? '0 : head_data;
  assign M_AXIS_TLAST  = ~empty & head_last;
  assign M_AXIS_TSTRB  = {(C_M_AXIS_TDATA_WIDTH/8){~empty}};

  assign free        = (AW+1)'(FIFO_DEPTH) - count;
  assign almost_full = (free <= (AW+1)'(ALMOST_FULL_MARGIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // Words buffered during DONE restart streaming without a new write.
      IDLE:    if (last_hs) state_nxt = DONE;
               else if (push || !empty) state_nxt = STREAM;
      STREAM:  if (last_hs) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == STREAM);
    layer_done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count <= '0;
      last_hs_q  <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear) begin
      beat_count <= '0;
      last_hs_q  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      last_hs_q <= last_hs;
      // Final count stays visible for one cycle, then the next packet starts.
      if (last_hs_q)                     beat_count <= pop ? CNT_WIDTH'(1) : '0;
      else if (pop && beat_count != '1) beat_count <= beat_count + 1'b1;
      if (in_valid && full && !pop) overflow <= 1'b1;
    end
  end

endmodule
